// File: rtl/logic_unit_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : logic_unit_pipe_pkg
//  Description : Opcode encoding and per-bit result function for the
//                pipelined logic unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package logic_unit_pipe_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        LOGIC_AND    = 3'b000,
        LOGIC_OR     = 3'b001,
        LOGIC_NAND   = 3'b010,
        LOGIC_NOR    = 3'b011,
        LOGIC_XOR    = 3'b100,
        LOGIC_XNOR   = 3'b101,
        LOGIC_NOT_A  = 3'b110,
        LOGIC_PASS_A = 3'b111
    } logic_op_e;

    // Single-bit result; the top replicates it across DATA_W so that any
    // operand width is supported without a fixed-width helper.
    function automatic logic logic_bit(input logic_op_e op, input logic a, input logic b);
        logic r;
        r = a & b;
        case (op)
            LOGIC_AND:    r = a & b;
            LOGIC_OR:     r = a | b;
            LOGIC_NAND:   r = ~(a & b);
            LOGIC_NOR:    r = ~(a | b);
            LOGIC_XOR:    r = a ^ b;
            LOGIC_XNOR:   r = ~(a ^ b);
            LOGIC_NOT_A:  r = ~a;
            LOGIC_PASS_A: r = a;
            default:      r = a & b;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/logic_pipe_slice.sv
`default_nettype none
// ============================================================================
//  Module      : logic_pipe_slice
//  Description : Valid/ready pipeline register with pass-through ready; holds
//                its payload while stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
module logic_pipe_slice #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             w_adv;

    assign w_adv       = !valid_q || out_ready_i;
    assign in_ready_o  = w_adv && !rst;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (w_adv) begin
            valid_d = in_valid_i;
            if (in_valid_i) begin
                data_d = in_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : logic_unit_pipe
//  Description : Two-stage valid/ready bitwise logic unit with tag and
//                optional reduction flags (macro LOGIC_UNIT_PIPE_FLAGS_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_pipe
    import logic_unit_pipe_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] A_IN,
    input  logic [DATA_W-1:0] B_IN,
    input  logic [OP_W-1:0]   ALU_FUN,
    input  logic [TAG_W-1:0]  TAG_IN,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] LOGIC_OUT,
    output logic [TAG_W-1:0]  TAG_OUT,
    output logic              ZERO_FLAG,
    output logic              ONES_FLAG,
    output logic              PARITY_FLAG
);

    localparam int S1_W = 2*DATA_W + OP_W + TAG_W;
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
    localparam int S2_W = DATA_W + TAG_W + 3;
`else
    localparam int S2_W = DATA_W + TAG_W;
`endif

    logic [S1_W-1:0]   w_s1_in, w_s1_out;
    logic [S2_W-1:0]   w_s2_in, w_s2_out;
    logic              w_s1_valid, w_s2_ready;
    logic [DATA_W-1:0] w_s1_a, w_s1_b, w_res;
    logic [OP_W-1:0]   w_s1_op;
    logic [TAG_W-1:0]  w_s1_tag;

    assign w_s1_in = {A_IN, B_IN, ALU_FUN, TAG_IN};

    logic_pipe_slice #(.WIDTH(S1_W)) u_s1 (
        .clk         (CLK),
        .rst         (RST),
        .in_valid_i  (IN_VALID),
        .in_ready_o  (IN_READY),
        .in_data_i   (w_s1_in),
        .out_valid_o (w_s1_valid),
        .out_ready_i (w_s2_ready),
        .out_data_o  (w_s1_out)
    );

    assign {w_s1_a, w_s1_b, w_s1_op, w_s1_tag} = w_s1_out;

    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        assign w_res[i] = logic_bit(logic_op_e'(w_s1_op), w_s1_a[i], w_s1_b[i]);
    end

`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
    // Flags are derived from the S1-side result so they register with it.
    assign w_s2_in = {w_res, w_s1_tag, ~|w_res, &w_res, ^w_res};
`else
    assign w_s2_in = {w_res, w_s1_tag};
`endif

    logic_pipe_slice #(.WIDTH(S2_W)) u_s2 (
        .clk         (CLK),
        .rst         (RST),
        .in_valid_i  (w_s1_valid),
        .in_ready_o  (w_s2_ready),
        .in_data_i   (w_s2_in),
        .out_valid_o (OUT_VALID),
        .out_ready_i (OUT_READY),
        .out_data_o  (w_s2_out)
    );

`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
    assign {LOGIC_OUT, TAG_OUT, ZERO_FLAG, ONES_FLAG, PARITY_FLAG} = w_s2_out;
`else
    assign {LOGIC_OUT, TAG_OUT} = w_s2_out;
    assign ZERO_FLAG   = 1'b0;
    assign ONES_FLAG   = 1'b0;
    assign PARITY_FLAG = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_logic_unit_pipe
//  Description : Directed and random self-checking bench for logic_unit_pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_pipe;

`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
    localparam logic FE = 1'b1;
`else
    localparam logic FE = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // 16-bit DUT
    logic        rst, iv, ordy, ir, ov, zf, of, pf;
    logic [15:0] a, b, lo;
    logic [2:0]  op;
    logic [3:0]  tg, to;

    // soak DUTs (DATA_W=1 and DATA_W=37) share handshake stimulus
    logic        siv, sordy, ir1, ov1, ir37, ov37;
    logic        zf1, of1, pf1, zf37, of37, pf37;
    logic [2:0]  sop;
    logic [4:0]  stg, to1, to37;
    logic [36:0] sa, sb, lo37;
    logic [0:0]  lo1;

    logic_unit_pipe #(.DATA_W(16), .TAG_W(4)) dut (
        .CLK(clk), .RST(rst), .IN_VALID(iv), .IN_READY(ir), .A_IN(a), .B_IN(b),
        .ALU_FUN(op), .TAG_IN(tg), .OUT_VALID(ov), .OUT_READY(ordy),
        .LOGIC_OUT(lo), .TAG_OUT(to), .ZERO_FLAG(zf), .ONES_FLAG(of), .PARITY_FLAG(pf)
    );

    logic_unit_pipe #(.DATA_W(1), .TAG_W(5)) dut_w1 (
        .CLK(clk), .RST(rst), .IN_VALID(siv), .IN_READY(ir1), .A_IN(sa[0:0]), .B_IN(sb[0:0]),
        .ALU_FUN(sop), .TAG_IN(stg), .OUT_VALID(ov1), .OUT_READY(sordy),
        .LOGIC_OUT(lo1), .TAG_OUT(to1), .ZERO_FLAG(zf1), .ONES_FLAG(of1), .PARITY_FLAG(pf1)
    );

    logic_unit_pipe #(.DATA_W(37), .TAG_W(5)) dut_w37 (
        .CLK(clk), .RST(rst), .IN_VALID(siv), .IN_READY(ir37), .A_IN(sa), .B_IN(sb),
        .ALU_FUN(sop), .TAG_IN(stg), .OUT_VALID(ov37), .OUT_READY(sordy),
        .LOGIC_OUT(lo37), .TAG_OUT(to37), .ZERO_FLAG(zf37), .ONES_FLAG(of37), .PARITY_FLAG(pf37)
    );

    function automatic logic [63:0] ref_op(input logic [2:0] f, input logic [63:0] x,
                                           input logic [63:0] y, input int w);
        logic [63:0] r, m;
        m = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        case (f)
            3'd0: r = x & y;
            3'd1: r = x | y;
            3'd2: r = ~(x & y);
            3'd3: r = ~(x | y);
            3'd4: r = x ^ y;
            3'd5: r = ~(x ^ y);
            3'd6: r = ~x;
            default: r = x;
        endcase
        return r & m;
    endfunction

    // Inputs are changed just after the falling edge; outputs are sampled 1 ns later.
    task automatic settle();
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; iv = 1'b1; a = 16'hABCD; b = 16'h1234; op = 3'd7; tg = 4'd3; ordy = 1'b1;
        siv = 1'b0; sordy = 1'b1; sop = 3'd0; stg = '0; sa = '0; sb = '0;
        next_cycle();
        next_cycle();
        settle();
        checks++; if (ir !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", ir); end
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", ov); end
        checks++; if (lo !== 16'h0 || to !== 4'h0) begin failures++; $display("FAIL reset_data got=%h/%h exp=0/0", lo, to); end
        checks++; if ({zf, of, pf} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {zf, of, pf}); end
        next_cycle();
        rst = 1'b0; iv = 1'b1; a = 16'h1234; op = 3'd7; tg = 4'd5;
        settle();
        checks++; if (ir !== 1'b1) begin failures++; $display("FAIL first_accept_ready got=%b exp=1", ir); end
        next_cycle();
        iv = 1'b0;
        settle();
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL first_latency_early got=%b exp=0", ov); end
        next_cycle();
        settle();
        checks++; if (ov !== 1'b1 || lo !== 16'h1234 || to !== 4'd5) begin
            failures++; $display("FAIL first_result got=%b/%h/%h exp=1/1234/5", ov, lo, to); end
        next_cycle();
        settle();
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL first_bubble got=%b exp=0", ov); end
        next_cycle();
    endtask

    task automatic test_opcode_sweep();
        logic [15:0] exp_r [8];
        exp_r = '{16'hF000, 16'hFFF0, 16'h0FFF, 16'h000F, 16'h0FF0, 16'hF00F, 16'h0F0F, 16'hF0F0};
        for (int i = 0; i < 11; i++) begin
            iv = (i < 8); a = 16'hF0F0; b = 16'hFF00; op = 3'(i); tg = 4'(i); ordy = 1'b1;
            settle();
            if (i < 8) begin
                checks++; if (ir !== 1'b1) begin failures++; $display("FAIL sweep_ready op=%0d got=%b exp=1", i, ir); end
            end
            if (i >= 2 && i < 10) begin
                checks++;
                if (ov !== 1'b1 || lo !== exp_r[i-2] || to !== 4'(i-2)) begin
                    failures++; $display("FAIL sweep_result op=%0d got=%b/%h/%h exp=1/%h/%h",
                                         i-2, ov, lo, to, exp_r[i-2], 4'(i-2));
                end
            end else if (i < 2 || i == 10) begin
                checks++; if (ov !== 1'b0) begin failures++; $display("FAIL sweep_idle i=%0d got=%b exp=0", i, ov); end
            end
            next_cycle();
        end
    endtask

    task automatic test_flags();
        logic [15:0] va [3], vb [3], vr [3];
        logic [2:0]  vo [3];
        logic [2:0]  vf [3];
        va = '{16'h00FF, 16'h0000, 16'h0001};
        vb = '{16'hFF00, 16'h0000, 16'hFFFF};
        vo = '{3'd0, 3'd3, 3'd7};
        vr = '{16'h0000, 16'hFFFF, 16'h0001};
        vf = '{3'b100, 3'b010, 3'b001};
        for (int i = 0; i < 5; i++) begin
            iv = (i < 3); ordy = 1'b1;
            if (i < 3) begin a = va[i]; b = vb[i]; op = vo[i]; tg = 4'(i + 1); end
            settle();
            if (i >= 2) begin
                checks++;
                if (ov !== 1'b1 || lo !== vr[i-2] || {zf, of, pf} !== (vf[i-2] & {3{FE}})) begin
                    failures++; $display("FAIL flags_case%0d got=%b/%h/%b exp=1/%h/%b",
                                         i-2, ov, lo, {zf, of, pf}, vr[i-2], vf[i-2] & {3{FE}});
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] vals [5];
        int idx, got;
        logic last_ir;
        vals = '{16'h1011, 16'h2122, 16'h3233, 16'h4344, 16'h5455};
        idx = 0; got = 0; last_ir = 1'b1;
        for (int c = 0; c < 6; c++) begin
            ordy = 1'b0; iv = 1'b1; op = 3'd7; b = 16'h0;
            a = vals[idx]; tg = 4'(idx);
            settle();
            last_ir = ir;
            if (c >= 2) begin
                checks++;
                if (ov !== 1'b1 || lo !== vals[0] || to !== 4'd0) begin
                    failures++; $display("FAIL bp_hold c=%0d got=%b/%h/%h exp=1/%h/0", c, ov, lo, to, vals[0]);
                end
            end
            if (ir) idx++;
            next_cycle();
        end
        checks++; if (idx != 2) begin failures++; $display("FAIL bp_accept_count got=%0d exp=2", idx); end
        checks++; if (last_ir !== 1'b0) begin failures++; $display("FAIL bp_ready_low got=%b exp=0", last_ir); end
        for (int c = 0; c < 25 && got < 5; c++) begin
            ordy = 1'b1; iv = (idx < 5);
            a = (idx < 5) ? vals[idx] : 16'h0; tg = 4'(idx);
            settle();
            if (ov) begin
                checks++;
                if (lo !== vals[got] || to !== 4'(got)) begin
                    failures++; $display("FAIL bp_order n=%0d got=%h/%h exp=%h/%h", got, lo, to, vals[got], 4'(got));
                end
                got++;
            end
            if (iv && ir) idx++;
            next_cycle();
        end
        checks++; if (got != 5) begin failures++; $display("FAIL bp_drain_count got=%0d exp=5", got); end
        iv = 1'b0;
        settle();
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL bp_no_dup got=%b exp=0", ov); end
        next_cycle();
    endtask

    task automatic test_midflight_reset();
        ordy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            iv = 1'b1; a = 16'hDEAD + 16'(i); op = 3'd7; tg = 4'(10 + i);
            next_cycle();
        end
        iv = 1'b0; rst = 1'b1;
        next_cycle();
        rst = 1'b0; ordy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++; if (ov !== 1'b0) begin failures++; $display("FAIL mid_reset_discard i=%0d got=%b exp=0", i, ov); end
            next_cycle();
        end
        iv = 1'b1; a = 16'h1234; b = 16'h00FF; op = 3'd4; tg = 4'd9;
        settle();
        checks++; if (ir !== 1'b1) begin failures++; $display("FAIL mid_reset_ready got=%b exp=1", ir); end
        next_cycle();
        iv = 1'b0;
        settle();
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL mid_reset_early got=%b exp=0", ov); end
        next_cycle();
        settle();
        checks++; if (ov !== 1'b1 || lo !== 16'h12CB || to !== 4'd9) begin
            failures++; $display("FAIL mid_reset_result got=%b/%h/%h exp=1/12cb/9", ov, lo, to); end
        next_cycle();
    endtask

    task automatic test_random_soak();
        logic [36:0] q37_d [$];
        logic [4:0]  q37_t [$], q1_t [$];
        logic        q1_d  [$];
        logic [63:0] r64;
        logic [36:0] e37;
        logic        e1;
        logic [4:0]  et;
        for (int c = 0; c < 400; c++) begin
            siv   = (c < 380) ? 1'($urandom_range(0, 1)) : 1'b0;
            sordy = (c < 380) ? ($urandom_range(0, 3) != 0) : 1'b1;
            sop = 3'($urandom); stg = 5'($urandom);
            sa = {5'($urandom), 32'($urandom)}; sb = {5'($urandom), 32'($urandom)};
            settle();
            if (siv && ir37) begin
                r64 = ref_op(sop, {27'b0, sa}, {27'b0, sb}, 37);
                q37_d.push_back(r64[36:0]); q37_t.push_back(stg);
            end
            if (siv && ir1) begin
                r64 = ref_op(sop, {63'b0, sa[0]}, {63'b0, sb[0]}, 1);
                q1_d.push_back(r64[0]); q1_t.push_back(stg);
            end
            if (ov37 && sordy) begin
                checks++;
                if (q37_d.size() == 0) begin
                    failures++; $display("FAIL soak37_extra got=%h exp=none", lo37);
                end else begin
                    e37 = q37_d.pop_front(); et = q37_t.pop_front();
                    if (lo37 !== e37 || to37 !== et) begin
                        failures++; $display("FAIL soak37_data got=%h/%h exp=%h/%h", lo37, to37, e37, et);
                    end
                end
            end
            if (ov1 && sordy) begin
                checks++;
                if (q1_d.size() == 0) begin
                    failures++; $display("FAIL soak1_extra got=%b exp=none", lo1);
                end else begin
                    e1 = q1_d.pop_front(); et = q1_t.pop_front();
                    if (lo1 !== e1 || to1 !== et) begin
                        failures++; $display("FAIL soak1_data got=%b/%h exp=%b/%h", lo1, to1, e1, et);
                    end
                end
            end
            next_cycle();
        end
        checks++;
        if (q37_d.size() != 0 || q1_d.size() != 0) begin
            failures++; $display("FAIL soak_leftover got=%0d/%0d exp=0/0", q37_d.size(), q1_d.size());
        end
    endtask

    initial begin
        test_reset();
        test_opcode_sweep();
        test_flags();
        test_backpressure();
        test_midflight_reset();
        test_random_soak();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
